uat_fifo: RTL and testbench

Parametrised serial transmitter for sending words over a UART line. It replaces the fixed 8N1, single-byte transmitter.
- Adds configurable data width, parity and stop bits.
- Adds a FIFO in front of the shifter so software and DMA can burst words without polling busy.
- Uses a valid/ready push interface. It sits between the AXI-Lite register block and the board's TX pin.

---
 rtl/uat_fifo.sv | 114 +++++++++++
 tb/tb_uat_fifo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uat_fifo.sv
// UART transmitter with a word FIFO in front of the frame shifter.
// Data width, parity mode and stop-bit count are set by parameters; bit timing comes from a 16-bit phase accumulator.
module uat_fifo #(
  parameter real CLK_FREQ   = 100e6,
  parameter real BAUD_RATE  = 115200,
  parameter int  DATA_BITS  = 8,
  parameter int  PARITY     = 0,
  parameter int  STOP_BITS  = 1,
  parameter int  FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          tx,
  input  logic [DATA_BITS-1:0]          data,
  input  logic                          valid,
  output logic                          ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int NB = 1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
  localparam logic [3:0]  NB4 = 4'(NB);
  localparam logic [15:0] INC = 16'($rtoi(65536.0 * BAUD_RATE / CLK_FREQ));

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state;
  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wptr;
  logic [AW-1:0]          rptr;
  logic                   push;
  logic                   pop;
  logic [DATA_BITS-1:0]   head;
  logic                   par;
  logic [NB-1:0]          frame;
  logic [NB-1:0]          shreg;
  logic [3:0]             cnt;
  logic [15:0]            tmr;
  logic [16:0]            tmr_sum;
  logic                   carry;

  // Handshake: a word is taken on any rising edge where valid && ready.
  // ready depends only on the registered level, never on valid.
  assign ready = (level != LW'(FIFO_DEPTH));
  assign push  = valid && ready;
  assign pop   = (state == IDLE) && (level != '0);
  assign busy  = (level != '0) || (state == SHIFT);
  assign tx    = shreg[0];
  assign head  = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Odd mode sets the parity bit when the data has an even number of ones.
  always_comb begin
    par = (PARITY == 1) ? ~(^head) : ^head;
    frame = '1;
    frame[0] = 1'b0;
    frame[DATA_BITS:1] = head;
    frame[DATA_BITS+1] = (PARITY == 0) ? 1'b1 : par;
  end

  assign tmr_sum = {1'b0, tmr} + {1'b0, INC};
  assign carry   = tmr_sum[16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '1;
      cnt   <= '0;
      tmr   <= '0;
    end else begin
      tmr <= tmr_sum[15:0];
      case (state)
        IDLE: begin
          if (level != '0) begin
            shreg <= frame;
            cnt   <= NB4;
            tmr   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (carry) begin
            shreg <= {1'b1, shreg[NB-1:1]};
            cnt   <= cnt - 1'b1;
            if (cnt == 4'd1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uat_fifo.sv
// Bench for uat_fifo: four configurations, directed steps, scoreboard of pushed words checked by a per-DUT tx monitor.
module tb_uat_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] data_a  [4];
  logic       valid_a [4];
  logic       tx_a    [4];
  logic       ready_a [4];
  logic       busy_a  [4];
  logic [4:0] level_a [4];

  logic [8:0] exp_q[$];
  int         start_q[$];

  // id 0: 8N1, id 1: 8E1, id 2: 8O1, id 3: 7N2 -- all at 16 clk per bit
  uat_fifo #(.CLK_FREQ(16e6), .BAUD_RATE(1e6)) u_base (
    .clk(clk), .rst_n(rst_n), .tx(tx_a[0]), .data(data_a[0]), .valid(valid_a[0]),
    .ready(ready_a[0]), .busy(busy_a[0]), .level(level_a[0]));
  uat_fifo #(.CLK_FREQ(16e6), .BAUD_RATE(1e6), .PARITY(2)) u_even (
    .clk(clk), .rst_n(rst_n), .tx(tx_a[1]), .data(data_a[1]), .valid(valid_a[1]),
    .ready(ready_a[1]), .busy(busy_a[1]), .level(level_a[1]));
  uat_fifo #(.CLK_FREQ(16e6), .BAUD_RATE(1e6), .PARITY(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .tx(tx_a[2]), .data(data_a[2]), .valid(valid_a[2]),
    .ready(ready_a[2]), .busy(busy_a[2]), .level(level_a[2]));
  uat_fifo #(.CLK_FREQ(16e6), .BAUD_RATE(1e6), .DATA_BITS(7), .STOP_BITS(2)) u_7b (
    .clk(clk), .rst_n(rst_n), .tx(tx_a[3]), .data(data_a[3][6:0]), .valid(valid_a[3]),
    .ready(ready_a[3]), .busy(busy_a[3]), .level(level_a[3]));

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic int nb_of(input int id);
    case (id)
      1, 2:    return 11;
      default: return 10;
    endcase
  endfunction

  // Independent frame model: bit b of the frame in transmit order.
  function automatic logic model_bit(input int id, input logic [8:0] w, input int b);
    int db;
    int pm;
    int ones;
    db = (id == 3) ? 7 : 8;
    pm = (id == 1) ? 2 : ((id == 2) ? 1 : 0);
    ones = 0;
    for (int i = 0; i < db; i++) ones += int'(w[i]);
    if (b == 0) return 1'b0;
    if (b <= db) return w[b-1];
    if (pm == 2 && b == db + 1) return (ones % 2) == 1;
    if (pm == 1 && b == db + 1) return (ones % 2) == 0;
    return 1'b1;
  endfunction

  task automatic monitor(input int id);
    logic [8:0] w;
    int nb;
    nb = nb_of(id);
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_a[id] === 1'b0) begin
        if (id == 0) start_q.push_back(cyc);
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_frame: observed a frame on dut %0d expected none", id);
        end
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          for (int c = 0; c < 16 * nb; c++) begin
            if (c > 0) @(negedge clk);
            if (rst_n !== 1'b1) break;
            if (c % 16 == 0 || c % 16 == 15)
              chk($sformatf("mon%0d_w%0h_bit%0d", id, w, c / 16), 32'(tx_a[id]), 32'(model_bit(id, w, c / 16)));
          end
        end else begin
          repeat (16 * nb - 1) @(negedge clk);
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);
  initial monitor(3);

  task automatic push_one(input int id, input logic [8:0] w);
    logic rdy;
    @(negedge clk);
    data_a[id]  = w[7:0];
    valid_a[id] = 1'b1;
    rdy = ready_a[id];
    @(posedge clk);
    if (rdy) exp_q.push_back(w);
    @(negedge clk);
    valid_a[id] = 1'b0;
  endtask

  // Push one word into an idle DUT and check latency, bit centres and frame length.
  task automatic send_check(input int id, input logic [8:0] w, input int nb, input logic [12:0] bits, input string tag);
    push_one(id, w);
    chk({tag, "_busy_rise"}, 32'(busy_a[id]), 32'd1);
    chk({tag, "_level_one"}, 32'(level_a[id]), 32'd1);
    for (int n = 2; n <= 2 + 16 * nb; n++) begin
      @(negedge clk);
      if (n == 2) chk({tag, "_tx_fall"}, 32'(tx_a[id]), 32'd0);
      if ((n - 2) % 16 == 8 && n < 2 + 16 * nb)
        chk($sformatf("%s_bit%0d", tag, (n - 2) / 16), 32'(tx_a[id]), 32'(bits[(n - 2) / 16]));
      if (n == 1 + 16 * nb) chk({tag, "_busy_last"}, 32'(busy_a[id]), 32'd1);
      if (n == 2 + 16 * nb) begin
        chk({tag, "_busy_fall"}, 32'(busy_a[id]), 32'd0);
        chk({tag, "_level_zero"}, 32'(level_a[id]), 32'd0);
        chk({tag, "_tx_idle"}, 32'(tx_a[id]), 32'd1);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int maxl;
    int waited;
    logic rdy;
    logic stayed;

    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_a[i]  = '0;
      valid_a[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_tx%0d", i), 32'(tx_a[i]), 32'd1);
      chk($sformatf("rst_ready%0d", i), 32'(ready_a[i]), 32'd1);
      chk($sformatf("rst_busy%0d", i), 32'(busy_a[i]), 32'd0);
      chk($sformatf("rst_level%0d", i), 32'(level_a[i]), 32'd0);
    end
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send_check(0, 9'h0A5, 10, 13'b0001101001010, "t1_a5");
    send_check(1, 9'h003, 11, 13'b0010000000110, "t2_even03");
    send_check(1, 9'h007, 11, 13'b0011000001110, "t2_even07");
    send_check(2, 9'h003, 11, 13'b0011000000110, "t2_odd03");
    send_check(2, 9'h007, 11, 13'b0010000001110, "t2_odd07");
    send_check(3, 9'h041, 10, 13'b0001110000010, "t3_7n2");

    // Valid held high with 0x00..0x13, then 0xFF offered while full.
    start_q.delete();
    acc  = 0;
    maxl = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      data_a[0]  = 8'(i);
      valid_a[0] = 1'b1;
      rdy = ready_a[0];
      if (int'(level_a[0]) > maxl) maxl = int'(level_a[0]);
      @(posedge clk);
      if (rdy) begin
        acc++;
        exp_q.push_back(9'(i));
      end
    end
    @(negedge clk);
    data_a[0] = 8'hFF;
    rdy = ready_a[0];
    chk("t6_ready_full", 32'(ready_a[0]), 32'd0);
    @(posedge clk);
    if (rdy) exp_q.push_back(9'h0FF);
    @(negedge clk);
    valid_a[0] = 1'b0;
    if (int'(level_a[0]) > maxl) maxl = int'(level_a[0]);
    chk("t4_accepted", 32'(acc), 32'd17);
    chk("t4_level_peak", 32'(maxl), 32'd16);
    chk("t6_level_unchanged", 32'(level_a[0]), 32'd16);
    chk("t4_ready_low", 32'(ready_a[0]), 32'd0);

    waited = 0;
    while (level_a[0] == 5'd16 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    chk("t4_level_after_pop", 32'(level_a[0]), 32'd15);
    chk("t4_ready_back", 32'(ready_a[0]), 32'd1);

    waited = 0;
    while ((exp_q.size() != 0 || busy_a[0] !== 1'b0) && waited < 4000) begin
      @(negedge clk);
      waited++;
    end
    chk("t4_drain_busy", 32'(busy_a[0]), 32'd0);
    chk("t4_drain_queue", 32'(exp_q.size()), 32'd0);
    chk("t4_frames", 32'(start_q.size()), 32'd17);
    for (int i = 1; i < start_q.size(); i++)
      chk($sformatf("t4_gap%0d", i), 32'(start_q[i] - start_q[i-1]), 32'd161);

    // Reset during bit 3 with five words still queued.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      data_a[0]  = 8'(8'h30 + i);
      valid_a[0] = 1'b1;
      rdy = ready_a[0];
      @(posedge clk);
      if (rdy) exp_q.push_back(9'(8'h30 + i));
    end
    @(negedge clk);
    valid_a[0] = 1'b0;
    chk("t5_level_queued", 32'(level_a[0]), 32'd5);
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_tx", 32'(tx_a[0]), 32'd1);
    chk("t5_rst_busy", 32'(busy_a[0]), 32'd0);
    chk("t5_rst_level", 32'(level_a[0]), 32'd0);
    chk("t5_rst_ready", 32'(ready_a[0]), 32'd1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    stayed = 1'b1;
    repeat (300) begin
      @(negedge clk);
      if (tx_a[0] !== 1'b1) stayed = 1'b0;
    end
    chk("t5_tx_stays_high", 32'(stayed), 32'd1);
    chk("t5_busy_after", 32'(busy_a[0]), 32'd0);
    chk("t5_level_after", 32'(level_a[0]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
